// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the 64-to-16 Wishbone width bridge.
// Provides the FSM state encoding and the lane geometry (four 16-bit
// halfword lanes inside one 64-bit doubleword).
package wb_bridge_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

endpackage

// File: rtl/wb_bridge64to16_lane_pick.sv
// Purpose : find the lowest active halfword lane at or above / strictly above lane_i.
// Latency : purely combinational, no state.
// Backpr. : none; a lane is active when either of its two byte selects is set.
// Ports   : sel_i byte selects, lane_i search origin, incl_i includes lane_i itself,
//           lane_o chosen lane, vld_o high when such a lane exists.
module lane_pick
    import wb_bridge_pkg::*;
(
    input  logic [7:0]        sel_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic              incl_i,
    output logic [LANE_W-1:0] lane_o,
    output logic              vld_o
);

    // Scan from the top down so the last hit written is the lowest lane.
    always_comb begin
        lane_o = '0;
        vld_o  = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if ((sel_i[2*k +: 2] != 2'b00) &&
                ((k > int'(lane_i)) || (incl_i && (k == int'(lane_i))))) begin
                lane_o = LANE_W'(k);
                vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bridge64to16.sv
// Purpose : split one 64-bit classic Wishbone transfer into 1..4 16-bit PSRAM halfword transfers.
// Latency : 1 + n*L + (n-1) + 1 cycles for n active lanes at downstream ack latency L.
// Backpr. : upstream held until s_ack_o; downstream waits for m_ack_i; no start while ram_busy_i.
// Ports   : s_* upstream 64-bit slave side, m_* downstream 16-bit master side,
//           ram_busy_i blocks new transactions (sampled in IDLE only). All outputs registered.
module wb_bridge64to16
    import wb_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ram_busy_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [7:0]  s_sel_i,
    input  logic [20:0] s_adr_i,
    input  logic [63:0] s_dat_i,
    output logic [63:0] s_dat_o,
    output logic        s_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    output logic [22:0] m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    input  logic        m_ack_i
);

    state_e                   state_q, state_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [20:0]              adr_q, adr_d;
    logic                     we_q, we_d;
    logic [LANES-1:0][1:0]    sel_q, sel_d;
    logic [LANES-1:0][15:0]   wdat_q, wdat_d;
    logic [LANES-1:0][15:0]   rbuf_q, rbuf_d;
    logic                     abort_q, abort_d;

    logic [63:0] s_dat_q, s_dat_d;
    logic        s_ack_q, s_ack_d;
    logic        m_cyc_q, m_cyc_d;
    logic        m_stb_q, m_stb_d;
    logic        m_we_q, m_we_d;
    logic [1:0]  m_sel_q, m_sel_d;
    logic [22:0] m_adr_q, m_adr_d;
    logic [15:0] m_dat_q, m_dat_d;

    logic [LANE_W-1:0] first_lane, next_lane;
    logic              first_vld, next_vld;
    logic              abort_now;

    // First active lane of the incoming request.
    lane_pick u_first (
        .sel_i  (s_sel_i),
        .lane_i ('0),
        .incl_i (1'b1),
        .lane_o (first_lane),
        .vld_o  (first_vld)
    );

    // Next active lane strictly above the one in flight.
    lane_pick u_next (
        .sel_i  (sel_q),
        .lane_i (lane_q),
        .incl_i (1'b0),
        .lane_o (next_lane),
        .vld_o  (next_vld)
    );

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        rbuf_d    = rbuf_q;
        abort_d   = abort_q;
        s_dat_d   = s_dat_q;
        s_ack_d   = 1'b0;
        m_cyc_d   = m_cyc_q;
        m_stb_d   = m_stb_q;
        m_we_d    = m_we_q;
        m_sel_d   = m_sel_q;
        m_adr_d   = m_adr_q;
        m_dat_d   = m_dat_q;
        // An upstream drop is remembered so a brief cyc glitch still aborts.
        abort_now = abort_q | ~s_cyc_i;

        case (state_q)
            ST_IDLE: begin
                if (s_cyc_i && s_stb_i && !ram_busy_i) begin
                    adr_d   = s_adr_i;
                    we_d    = s_we_i;
                    sel_d   = s_sel_i;
                    wdat_d  = s_dat_i;
                    rbuf_d  = '0;
                    abort_d = 1'b0;
                    if (!first_vld) begin
                        // No byte enabled: acknowledge without touching the PSRAM.
                        state_d = ST_ACK;
                        s_ack_d = 1'b1;
                        s_dat_d = '0;
                        m_cyc_d = 1'b0;
                    end else begin
                        state_d = ST_REQ;
                        lane_d  = first_lane;
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        m_we_d  = s_we_i;
                        m_sel_d = s_sel_i[2*first_lane +: 2];
                        m_adr_d = {s_adr_i, first_lane};
                        m_dat_d = s_dat_i[16*first_lane +: 16];
                    end
                end
            end

            ST_REQ: begin
                abort_d = abort_now;
                if (m_ack_i) begin
                    if (!we_q) begin
                        rbuf_d[lane_q] = m_dat_i;
                    end
                    m_stb_d = 1'b0;
                    if (abort_now) begin
                        state_d = ST_IDLE;
                        m_cyc_d = 1'b0;
                        m_we_d  = 1'b0;
                    end else if (next_vld) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ACK;
                        s_ack_d = 1'b1;
                        s_dat_d = rbuf_d;
                        m_cyc_d = 1'b0;
                        m_we_d  = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                abort_d = abort_now;
                if (abort_now) begin
                    state_d = ST_IDLE;
                    m_cyc_d = 1'b0;
                    m_we_d  = 1'b0;
                end else begin
                    state_d = ST_REQ;
                    lane_d  = next_lane;
                    m_stb_d = 1'b1;
                    m_we_d  = we_q;
                    m_sel_d = sel_q[next_lane];
                    m_adr_d = {adr_q, next_lane};
                    m_dat_d = wdat_q[next_lane];
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rbuf_q  <= '0;
            abort_q <= 1'b0;
            s_dat_q <= '0;
            s_ack_q <= 1'b0;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_sel_q <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rbuf_q  <= rbuf_d;
            abort_q <= abort_d;
            s_dat_q <= s_dat_d;
            s_ack_q <= s_ack_d;
            m_cyc_q <= m_cyc_d;
            m_stb_q <= m_stb_d;
            m_we_q  <= m_we_d;
            m_sel_q <= m_sel_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
        end
    end

    assign s_dat_o = s_dat_q;
    assign s_ack_o = s_ack_q;
    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_sel_o = m_sel_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_wb_bridge64to16.sv
// Testbench for wb_bridge64to16: directed transfers, a PSRAM responder with
// configurable ack latency, and scoreboards for downstream halfwords and upstream acks.
module tb_wb_bridge64to16;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        ram_busy_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic        s_we_i = 1'b0;
    logic [7:0]  s_sel_i = '0;
    logic [20:0] s_adr_i = '0;
    logic [63:0] s_dat_i = '0;
    logic [63:0] s_dat_o;
    logic        s_ack_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [1:0]  m_sel_o;
    logic [22:0] m_adr_o;
    logic [15:0] m_dat_o;
    logic [15:0] m_dat_i = '0;
    logic        m_ack_i = 1'b0;

    wb_bridge64to16 dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .ram_busy_i (ram_busy_i),
        .s_cyc_i    (s_cyc_i),
        .s_stb_i    (s_stb_i),
        .s_we_i     (s_we_i),
        .s_sel_i    (s_sel_i),
        .s_adr_i    (s_adr_i),
        .s_dat_i    (s_dat_i),
        .s_dat_o    (s_dat_o),
        .s_ack_o    (s_ack_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_we_o     (m_we_o),
        .m_sel_o    (m_sel_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_dat_i    (m_dat_i),
        .m_ack_i    (m_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [63:0] up_q[$];     // expected s_dat_o per upstream ack
    logic [41:0] down_q[$];   // expected {adr, sel, we, dat} per downstream handshake
    logic [15:0] rd_q[$];     // read data the responder returns
    int          lat = 1;     // responder ack latency in cycles
    int          gap_cnt = 0;
    bit          cyc_seen = 0;
    bit          ack_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [41:0] dn(input logic [22:0] adr, input logic [1:0] sel,
                                       input logic we, input logic [15:0] dat);
        return {adr, sel, we, dat};
    endfunction

    // PSRAM responder: acks after lat cycles of strobe, returns queued read data.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk_i); #1;
            m_ack_i = 1'b0;
            if (m_stb_o) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    m_ack_i  = 1'b1;
                    wait_cnt = 0;
                    if (!m_we_o && rd_q.size() > 0) m_dat_i = rd_q.pop_front();
                    else m_dat_i = 16'hDEAD;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitors, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (m_cyc_o) cyc_seen = 1;
            if (m_cyc_o && !m_stb_o) gap_cnt++;
            if (m_stb_o && m_ack_i) begin
                if (down_q.size() == 0) chk("down_unexpected", 64'(dn(m_adr_o, m_sel_o, m_we_o, m_dat_o)), 64'd0);
                else chk("down_xfer", 64'(dn(m_adr_o, m_sel_o, m_we_o, m_dat_o)), 64'(down_q.pop_front()));
            end
            if (s_ack_o) begin
                ack_seen = 1;
                if (up_q.size() == 0) chk("up_unexpected_ack", 64'd1, 64'd0);
                else chk("s_dat_o", s_dat_o, up_q.pop_front());
            end
        end
    end

    task automatic start_req(input logic we, input logic [7:0] sel,
                             input logic [20:0] adr, input logic [63:0] dat);
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        s_we_i = we; s_sel_i = sel; s_adr_i = adr; s_dat_i = dat;
    endtask

    // Counts cycles from the current cycle (0) to the s_ack_o cycle.
    task automatic wait_ack(input string nm, input int exp_lat);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk_i); #1;
            cyc++;
        end while (!s_ack_o && cyc < 200);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        chk(nm, 64'(cyc), 64'(exp_lat));
        @(posedge clk_i); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outs", 64'({s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}), 64'd0);
        chk("reset_sdat", s_dat_o, 64'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        // Full read, four lanes, L=3.
        lat = 3; gap_cnt = 0;
        rd_q.push_back(16'h1111); rd_q.push_back(16'h2222);
        rd_q.push_back(16'h3333); rd_q.push_back(16'h4444);
        for (int k = 0; k < 4; k++) down_q.push_back(dn(23'h40 + 23'(k), 2'b11, 1'b0, 16'h0));
        up_q.push_back(64'h4444_3333_2222_1111);
        start_req(1'b0, 8'hFF, 21'h000010, 64'h0);
        wait_ack("lat_full_read", 16);
        chk("gaps_full_read", 64'(gap_cnt), 64'd3);

        // Single-lane write, lane 1, L=2.
        lat = 2;
        down_q.push_back(dn(23'h81, 2'b11, 1'b1, 16'hCCCC));
        up_q.push_back(64'h0);
        start_req(1'b1, 8'h0C, 21'h000020, 64'hAAAA_BBBB_CCCC_DDDD);
        wait_ack("lat_single_write", 3);

        // Sparse read at the top address, lanes 0 and 3, L=1.
        lat = 1;
        rd_q.push_back(16'h5A5A); rd_q.push_back(16'hA5A5);
        down_q.push_back(dn(23'h7FFFFC, 2'b01, 1'b0, 16'h0));
        down_q.push_back(dn(23'h7FFFFF, 2'b10, 1'b0, 16'h0));
        up_q.push_back(64'hA5A5_0000_0000_5A5A);
        start_req(1'b0, 8'h81, 21'h1FFFFF, 64'h0);
        wait_ack("lat_sparse_read", 4);

        // Empty select: immediate ack, no downstream cycle.
        cyc_seen = 0;
        up_q.push_back(64'h0);
        start_req(1'b0, 8'h00, 21'h000123, 64'h0);
        wait_ack("lat_empty_sel", 1);
        chk("empty_sel_no_cyc", 64'(cyc_seen), 64'd0);

        // Busy hold-off for 10 cycles.
        cyc_seen = 0;
        ram_busy_i = 1'b1;
        start_req(1'b0, 8'h03, 21'h000005, 64'h0);
        repeat (10) @(posedge clk_i);
        #1;
        chk("busy_no_cyc", 64'(cyc_seen), 64'd0);
        rd_q.push_back(16'h1234);
        down_q.push_back(dn(23'h14, 2'b11, 1'b0, 16'h0));
        up_q.push_back(64'h0000_0000_0000_1234);
        ram_busy_i = 1'b0;
        wait_ack("lat_after_busy", 2);

        // Upstream abort during lane 0: lane 0 completes, no ack.
        lat = 2; ack_seen = 0;
        rd_q.push_back(16'h7777);
        down_q.push_back(dn(23'h8, 2'b11, 1'b0, 16'h0));
        start_req(1'b0, 8'hFF, 21'h000002, 64'h0);
        @(posedge clk_i); #1;
        chk("abort_stb_started", 64'(m_stb_o), 64'd1);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #1;
        chk("abort_no_ack", 64'(ack_seen), 64'd0);
        chk("abort_cyc_low", 64'(m_cyc_o), 64'd0);
        chk("abort_down_done", 64'(down_q.size()), 64'd0);

        // Reset during lane 2 request.
        lat = 3;
        rd_q.push_back(16'h0A0A); rd_q.push_back(16'h0B0B);
        down_q.push_back(dn(23'h0, 2'b11, 1'b0, 16'h0));
        down_q.push_back(dn(23'h1, 2'b11, 1'b0, 16'h0));
        start_req(1'b0, 8'hFF, 21'h000000, 64'h0);
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk_i); #1;
                n++;
            end while (!(m_stb_o && m_adr_o[1:0] == 2'd2) && n < 100);
            chk("reached_lane2", 64'(n < 100), 64'd1);
        end
        reset_i = 1'b1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        @(posedge clk_i); #1;
        chk("midreset_outs", 64'({s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}), 64'd0);
        chk("midreset_sdat", s_dat_o, 64'd0);
        chk("midreset_down_done", 64'(down_q.size()), 64'd0);
        reset_i = 1'b0;
        up_q.delete(); rd_q.delete();
        @(posedge clk_i); #1;

        // Fresh write after reset, lanes 2 and 3, L=1.
        lat = 1;
        down_q.push_back(dn(23'h2AF36, 2'b11, 1'b1, 16'h4567));
        down_q.push_back(dn(23'h2AF37, 2'b11, 1'b1, 16'h0123));
        up_q.push_back(64'h0);
        start_req(1'b1, 8'hF0, 21'h00ABCD, 64'h0123_4567_89AB_CDEF);
        wait_ack("lat_post_reset_write", 4);

        repeat (3) @(posedge clk_i);
        #1;
        chk("down_q_drained", 64'(down_q.size()), 64'd0);
        chk("up_q_drained", 64'(up_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
